// File: rtl/store_buffer.sv
// store_buffer: posted-write queue in front of the data memory write port.
// Stores are accepted every cycle while space remains and retire in order
// whenever the memory port is not needed by a load. A load that touches a
// word with a pending store holds in MEM while the oldest entry drains.
// Optional feature macro: STORE_FWD_EN (forward a single matching SW to a load).
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             st_valid_i,
  input  logic [31:0]      st_addr_i,
  input  logic [31:0]      st_data_i,
  input  logic [2:0]       st_funct3_i,
  output logic             st_ready_o,
  input  logic             ld_valid_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [2:0]       ld_funct3_i,
  output logic             ld_stall_o,
  output logic             fwd_valid_o,
  output logic [31:0]      fwd_data_o,
  output logic             mem_write_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [2:0]       mem_funct3_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; the valid bits and pointers are the only reset state.
  logic [31:0]      ent_addr   [DEPTH];
  logic [31:0]      ent_data   [DEPTH];
  logic [2:0]       ent_funct3 [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [DEPTH-1:0] hit;
  logic             hazard;
  logic             empty;
  logic             push;
  logic             pop;

  // Stores with an unknown width are kept as byte stores so memory sees SB.
  function automatic logic [2:0] store_kind(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: store_kind = f3;
      default:                store_kind = 3'b000;
    endcase
  endfunction

  // True when the access starting at byte offset lo runs into the next word.
  function automatic logic spills(input logic [1:0] lo, input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: spills = (lo == 2'b11);
      3'b010:         spills = (lo != 2'b00);
      default:        spills = 1'b0;
    endcase
  endfunction

  // Word-granular range intersection of two accesses.
  function automatic logic words_overlap(input logic [31:0] a, input logic [2:0] fa,
                                         input logic [31:0] b, input logic [2:0] fb);
    logic [29:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = a[31:2];
    a_hi = a[31:2] + 30'(spills(a[1:0], fa));
    b_lo = b[31:2];
    b_hi = b[31:2] + 30'(spills(b[1:0], fb));
    words_overlap = (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

`ifdef STORE_FWD_EN
  // Load widths that can be served from a full-word store at the same address.
  function automatic logic fwd_able(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: fwd_able = 1'b1;
      default:                                fwd_able = 1'b0;
    endcase
  endfunction

  // Sign/zero extension of the low part of a stored word per load width.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (f3)
      3'b000:  load_extend = 32'(b);
      3'b001:  load_extend = 32'(h);
      3'b100:  load_extend = {24'd0, d[7:0]};
      3'b101:  load_extend = {16'd0, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction
`endif

  assign empty      = (count == '0);
  assign empty_o    = empty;
  assign count_o    = count;
  assign st_ready_o = (count < FULL_CNT);
  assign push       = st_valid_i & st_ready_o;

  // Compare the load against every pending entry; this cycle's push is not yet stored.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = ent_valid[i] & words_overlap(ent_addr[i], ent_funct3[i], ld_addr_i, ld_funct3_i);
    end
    hazard = ld_valid_i & (|hit);
  end

`ifdef STORE_FWD_EN
  logic             fwd_seen;
  logic             fwd_multi;
  logic [PTR_W-1:0] fwd_idx;
  logic             fwd_ok;

  // Forward only when exactly one entry matches and it is a SW at the load address.
  always_comb begin
    fwd_seen  = 1'b0;
    fwd_multi = 1'b0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) begin
        if (fwd_seen) fwd_multi = 1'b1;
        fwd_seen = 1'b1;
        fwd_idx  = PTR_W'(i);
      end
    end
    fwd_ok = hazard & fwd_seen & ~fwd_multi &
             (ent_addr[fwd_idx] == ld_addr_i) &
             (ent_funct3[fwd_idx] == 3'b010) &
             fwd_able(ld_funct3_i);
    fwd_valid_o = fwd_ok;
    fwd_data_o  = fwd_ok ? load_extend(ent_data[fwd_idx], ld_funct3_i) : 32'd0;
  end
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_data_o  = 32'd0;
`endif

  assign ld_stall_o = hazard & ~fwd_valid_o;
  assign pop        = ~empty & (~ld_valid_i | ld_stall_o);

  // The head entry drives the memory port only in a draining cycle.
  always_comb begin
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = 32'd0;
    mem_funct3_o = 3'b000;
    if (pop) begin
      mem_write_o  = 1'b1;
      mem_addr_o   = ent_addr[rd_ptr];
      mem_data_o   = ent_data[rd_ptr];
      mem_funct3_o = ent_funct3[rd_ptr];
    end
  end

  // Payload capture on an accepted store.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      ent_addr[wr_ptr]   <= st_addr_i;
      ent_data[wr_ptr]   <= st_data_i;
      ent_funct3[wr_ptr] <= store_kind(st_funct3_i);
    end
  end

  // Queue bookkeeping; reset discards all pending stores immediately.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      ent_valid <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; memory writes are checked in order
// against a queue of expected retirements filled as stores are issued.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_stall;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } wr_t;

  wr_t exp_q[$];

  store_buffer dut (
    .sys_clk      (clk),
    .sys_reset    (rst),
    .st_valid_i   (st_valid),
    .st_addr_i    (st_addr),
    .st_data_i    (st_data),
    .st_funct3_i  (st_funct3),
    .st_ready_o   (st_ready),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_funct3_i  (ld_funct3),
    .ld_stall_o   (ld_stall),
    .fwd_valid_o  (fwd_valid),
    .fwd_data_o   (fwd_data),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .mem_funct3_o (mem_funct3),
    .empty_o      (empty),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f3, input bit expect_retire);
    wr_t e;
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
    if (expect_retire) begin
      e.addr = a;
      e.data = d;
      e.f3   = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ? f3 : 3'b000;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_store();
    st_valid  = 1'b0;
    st_addr   = 32'd0;
    st_data   = 32'd0;
    st_funct3 = 3'b000;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [2:0] f3);
    ld_valid  = v;
    ld_addr   = a;
    ld_funct3 = f3;
  endtask

  // Every memory write must be the oldest outstanding expected retirement.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      wr_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr 0x%08h expected no write", mem_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_data, e.data);
        check("wr_funct3", 32'(mem_funct3), 32'(e.f3));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_store();
    set_load(1'b0, 32'd0, 3'b000);

    // Reset state
    tick();
    tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_stall", 32'(ld_stall), 32'd0);
    check("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Single SW retires the cycle after it is accepted
    drive_store(32'h0000_0404, 32'hDEAD_BEEF, 3'b010, 1'b1);
    #1;
    check("sw_no_same_cycle_drain", 32'(mem_write), 32'd0);
    tick();
    idle_store();
    #1;
    check("sw_count1", 32'(count), 32'd1);
    check("sw_mem_write", 32'(mem_write), 32'd1);
    check("sw_mem_addr", mem_addr, 32'h0000_0404);
    check("sw_mem_funct3", 32'(mem_funct3), 32'd2);
    tick();
    check("sw_count0", 32'(count), 32'd0);
    check("sw_empty", 32'(empty), 32'd1);

    // Fill to full behind a non-hazard load, then drain in order
    set_load(1'b1, 32'h0000_0500, 3'b010);
    drive_store(32'h0000_0600, 32'h1111_0001, 3'b010, 1'b1);
    #1;
    check("fill_hold0", 32'(mem_write), 32'd0);
    tick();
    drive_store(32'h0000_0604, 32'h1122_3344, 3'b000, 1'b1);
    #1;
    check("fill_hold1", 32'(mem_write), 32'd0);
    tick();
    drive_store(32'h0000_0608, 32'h0000_BEEF, 3'b001, 1'b1);
    #1;
    check("fill_hold2", 32'(mem_write), 32'd0);
    tick();
    drive_store(32'h0000_060C, 32'h4444_0004, 3'b010, 1'b1);
    tick();
    drive_store(32'h0000_06F0, 32'hBAD0_BAD0, 3'b010, 1'b0);
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(st_ready), 32'd0);
    check("full_mem_write", 32'(mem_write), 32'd0);
    check("full_no_stall", 32'(ld_stall), 32'd0);
    tick();
    check("full_reject", 32'(count), 32'd4);
    set_load(1'b0, 32'd0, 3'b000);
    #1;
    check("full_no_bypass_ready", 32'(st_ready), 32'd0);
    check("full_drain_addr", mem_addr, 32'h0000_0600);
    tick();
    idle_store();
    check("drain_count3", 32'(count), 32'd3);
    tick();
    check("drain_count2", 32'(count), 32'd2);
    tick();
    check("drain_count1", 32'(count), 32'd1);
    tick();
    check("drain_count0", 32'(count), 32'd0);

    // SB in the load's word forces a one-cycle stall
    drive_store(32'h0000_0407, 32'h0000_0055, 3'b000, 1'b1);
    tick();
    idle_store();
    set_load(1'b1, 32'h0000_0404, 3'b010);
    #1;
    check("sb_hazard_stall", 32'(ld_stall), 32'd1);
    check("sb_hazard_drain", 32'(mem_write), 32'd1);
    tick();
    check("sb_hazard_released", 32'(ld_stall), 32'd0);
    check("sb_load_port_free", 32'(mem_write), 32'd0);
    set_load(1'b0, 32'd0, 3'b000);

    // Word-crossing SH hits a byte load in the following word
    set_load(1'b1, 32'h0000_0408, 3'b000);
    drive_store(32'h0000_0407, 32'h0000_BEEF, 3'b001, 1'b1);
    #1;
    check("sh_push_not_hazard", 32'(ld_stall), 32'd0);
    tick();
    idle_store();
    check("sh_cross_stall", 32'(ld_stall), 32'd1);
    check("sh_cross_funct3", 32'(mem_funct3), 32'd1);
    tick();
    check("sh_cross_released", 32'(ld_stall), 32'd0);

    // Neighbouring word does not stall; same word at its top byte does
    set_load(1'b1, 32'h0000_0704, 3'b010);
    drive_store(32'h0000_0700, 32'h7777_7777, 3'b010, 1'b1);
    tick();
    idle_store();
    check("neighbour_no_stall", 32'(ld_stall), 32'd0);
    check("neighbour_held", 32'(count), 32'd1);
    set_load(1'b1, 32'h0000_0703, 3'b000);
    #1;
    check("topbyte_stall", 32'(ld_stall), 32'd1);
    tick();
    check("topbyte_drained", 32'(count), 32'd0);
    set_load(1'b0, 32'd0, 3'b000);

    // SW then LB at the same address: forwarded or stalled
    drive_store(32'h0000_0410, 32'h0000_80F0, 3'b010, 1'b1);
    tick();
    idle_store();
    set_load(1'b1, 32'h0000_0410, 3'b000);
    #1;
`ifdef STORE_FWD_EN
    check("fwd_lb_valid", 32'(fwd_valid), 32'd1);
    check("fwd_lb_data", fwd_data, 32'hFFFF_FFF0);
    check("fwd_lb_no_stall", 32'(ld_stall), 32'd0);
    check("fwd_no_drain", 32'(mem_write), 32'd0);
    ld_funct3 = 3'b100;
    #1;
    check("fwd_lbu_data", fwd_data, 32'h0000_00F0);
    ld_funct3 = 3'b001;
    #1;
    check("fwd_lh_data", fwd_data, 32'hFFFF_80F0);
    ld_funct3 = 3'b101;
    #1;
    check("fwd_lhu_data", fwd_data, 32'h0000_80F0);
    ld_funct3 = 3'b010;
    #1;
    check("fwd_lw_data", fwd_data, 32'h0000_80F0);
    set_load(1'b0, 32'd0, 3'b000);
    #1;
    check("fwd_later_drain", 32'(mem_write), 32'd1);
`else
    check("nofwd_stall", 32'(ld_stall), 32'd1);
    check("nofwd_valid", 32'(fwd_valid), 32'd0);
    check("nofwd_data", fwd_data, 32'd0);
    check("nofwd_drain", 32'(mem_write), 32'd1);
    set_load(1'b0, 32'd0, 3'b000);
`endif
    tick();
    check("fwd_case_empty", 32'(count), 32'd0);

    // Unknown store width retires as SB
    drive_store(32'h0000_0800, 32'h0000_00A5, 3'b111, 1'b1);
    tick();
    idle_store();
    check("bad_f3_as_sb", 32'(mem_funct3), 32'd0);
    tick();

    // Push and pop in the same cycle keep the count
    drive_store(32'h0000_0900, 32'h1111_1111, 3'b010, 1'b1);
    tick();
    drive_store(32'h0000_0904, 32'h2222_2222, 3'b010, 1'b1);
    #1;
    check("pushpop_head", mem_addr, 32'h0000_0900);
    tick();
    idle_store();
    check("pushpop_count", 32'(count), 32'd1);
    check("pushpop_next", mem_addr, 32'h0000_0904);
    tick();
    check("pushpop_empty", 32'(count), 32'd0);

    // Reset in a draining cycle discards the pending store
    drive_store(32'h0000_0A00, 32'hAAAA_0000, 3'b010, 1'b1);
    tick();
    drive_store(32'h0000_0A04, 32'hAAAA_0004, 3'b010, 1'b0);
    tick();
    idle_store();
    check("pre_reset_draining", mem_addr, 32'h0000_0A04);
    rst = 1'b1;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_no_write", 32'(mem_write), 32'd0);
    check("midrst_ready", 32'(st_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_no_write", 32'(mem_write), 32'd0);
    tick();

    check("all_retired", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
